tetris_ctrl: RTL and testbench



---
 rtl/tetris_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tetris_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_ctrl.sv
// Falling-piece game controller: spawns pieces from an LFSR, applies gravity and
// key moves using the board store's enables, and hands off locks and line clears.
module tetris_ctrl #(
  parameter int unsigned DROP_TICKS = 25000000,
  parameter int unsigned SPAWN_X    = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_key_l,
  input  logic       i_key_r,
  input  logic       i_key_rot,
  input  logic       i_key_down,
  input  logic       i_key_boom,
  input  logic       i_el,
  input  logic       i_er,
  input  logic       i_eu,
  input  logic       i_edrop,
  input  logic       i_overflow,
  input  logic       i_refresh_done,
  input  logic [3:0] i_cnt_boom,
  output logic [4:0] o_x,
  output logic [4:0] o_y,
  output logic [2:0] o_type,
  output logic [1:0] o_dir,
  output logic [2:0] o_next_type,
  output logic       o_refresh,
  output logic       o_boom,
  output logic       o_playing,
  output logic       o_game_over
);

  localparam int unsigned   TW        = $clog2(DROP_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(DROP_TICKS - 1);
  localparam logic [4:0]    X_SPAWN   = 5'(SPAWN_X);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_CHECK, S_FALL, S_LOCK, S_WAITREF, S_OVER
  } state_t;

  // Piece shape from LFSR bits; the all-zero pattern is folded onto shape 1
  function automatic logic [2:0] map_piece(input logic [7:0] v);
    return (v[2:0] != 3'd0) ? v[2:0] : 3'd1;
  endfunction

  state_t        r_state;
  logic [7:0]    r_lfsr;
  logic [TW-1:0] r_timer;
  logic [4:0]    r_x;
  logic [4:0]    r_y;
  logic [2:0]    r_type;
  logic [1:0]    r_dir;
  logic [2:0]    r_next_type;
  logic          r_refresh;
  logic          r_boom;
  logic          r_playing;
  logic          r_game_over;

  logic          w_tick;
  logic          w_lfsr_fb;

  assign w_tick    = (r_timer == TICK_LAST);
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Free-running piece generator, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  // Game FSM with registered piece state and one-cycle request pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_x         <= X_SPAWN;
      r_y         <= 5'd0;
      r_type      <= 3'd0;
      r_dir       <= 2'd0;
      r_next_type <= map_piece(LFSR_SEED);
      r_refresh   <= 1'b0;
      r_boom      <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_refresh <= 1'b0;
      r_boom    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_SPAWN;
            r_playing <= 1'b1;
          end
        end
        S_SPAWN: begin
          r_x         <= X_SPAWN;
          r_y         <= 5'd0;
          r_dir       <= 2'd0;
          r_type      <= r_next_type;
          r_next_type <= map_piece(r_lfsr);
          r_timer     <= '0;
          r_state     <= S_CHECK;
        end
        S_CHECK: begin
          if (i_overflow) begin
            r_state     <= S_OVER;
            r_playing   <= 1'b0;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_FALL;
          end
        end
        S_FALL: begin
          if (!i_pause) begin
            if (w_tick) begin
              r_timer <= '0;
              if (i_edrop) r_y <= r_y + 5'd1;
              else begin
                r_state   <= S_LOCK;
                r_refresh <= 1'b1;
              end
            end else begin
              r_timer <= r_timer + TW'(1);
              if (i_key_rot) begin
                if (i_eu) r_dir <= r_dir + 2'd1;
              end else if (i_key_l) begin
                if (i_el) r_x <= r_x - 5'd1;
              end else if (i_key_r) begin
                if (i_er) r_x <= r_x + 5'd1;
              end else if (i_key_down) begin
                r_timer <= '0;
                if (i_edrop) r_y <= r_y + 5'd1;
                else begin
                  r_state   <= S_LOCK;
                  r_refresh <= 1'b1;
                end
              end else if (i_key_boom) begin
                if (i_cnt_boom != 4'd0) r_boom <= 1'b1;
              end
            end
          end
        end
        S_LOCK: begin
          r_state <= S_WAITREF;
        end
        S_WAITREF: begin
          if (i_refresh_done) r_state <= S_SPAWN;
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_type      = r_type;
  assign o_dir       = r_dir;
  assign o_next_type = r_next_type;
  assign o_refresh   = r_refresh;
  assign o_boom      = r_boom;
  assign o_playing   = r_playing;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_tetris_ctrl.sv
// Directed bench for tetris_ctrl with DROP_TICKS=4, SPAWN_X=3.
module tb_tetris_ctrl;

  logic       clk;
  logic       rstn;
  logic       i_start, i_pause, i_key_l, i_key_r, i_key_rot, i_key_down, i_key_boom;
  logic       i_el, i_er, i_eu, i_edrop, i_overflow, i_refresh_done;
  logic [3:0] i_cnt_boom;
  logic [4:0] o_x, o_y;
  logic [2:0] o_type, o_next_type;
  logic [1:0] o_dir;
  logic       o_refresh, o_boom, o_playing, o_game_over;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_lfsr, m_prev;
  logic [2:0] exp_next, cur_type;

  tetris_ctrl #(.DROP_TICKS(4), .SPAWN_X(3), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_pause(i_pause),
    .i_key_l(i_key_l), .i_key_r(i_key_r), .i_key_rot(i_key_rot),
    .i_key_down(i_key_down), .i_key_boom(i_key_boom),
    .i_el(i_el), .i_er(i_er), .i_eu(i_eu), .i_edrop(i_edrop),
    .i_overflow(i_overflow), .i_refresh_done(i_refresh_done), .i_cnt_boom(i_cnt_boom),
    .o_x(o_x), .o_y(o_y), .o_type(o_type), .o_dir(o_dir), .o_next_type(o_next_type),
    .o_refresh(o_refresh), .o_boom(o_boom), .o_playing(o_playing), .o_game_over(o_game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR; m_prev holds the value seen during the previous cycle
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  function automatic logic [2:0] shape_of(input logic [7:0] v);
    return (v[2:0] == 3'd0) ? 3'd1 : v[2:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_keys;
    i_key_l = 0; i_key_r = 0; i_key_rot = 0; i_key_down = 0; i_key_boom = 0;
    i_el = 0; i_er = 0; i_eu = 0;
  endtask

  task automatic test_reset;
    checks++; if (o_x !== 5'd3) begin errors++; $display("FAIL rst_x got %0d exp 3", o_x); end
    checks++; if (o_y !== 5'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", o_y); end
    checks++; if (o_type !== 3'd0) begin errors++; $display("FAIL rst_type got %0d exp 0", o_type); end
    checks++; if (o_dir !== 2'd0) begin errors++; $display("FAIL rst_dir got %0d exp 0", o_dir); end
    checks++; if (o_next_type !== 3'd5) begin errors++; $display("FAIL rst_next got %0d exp 5", o_next_type); end
    checks++; if ({o_refresh, o_boom, o_playing, o_game_over} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags got %b exp 0000", {o_refresh, o_boom, o_playing, o_game_over}); end
    rstn = 1;
    repeat (3) step;
    checks++; if (o_playing !== 1'b0 || o_type !== 3'd0) begin
      errors++; $display("FAIL idle_hold got playing=%b type=%0d exp 0/0", o_playing, o_type); end
  endtask

  task automatic test_fall;
    i_edrop = 1; i_overflow = 0;
    i_start = 1; step; i_start = 0;
    checks++; if (o_playing !== 1'b1 || o_type !== 3'd0) begin
      errors++; $display("FAIL spawn_enter got playing=%b type=%0d exp 1/0", o_playing, o_type); end
    step;
    exp_next = shape_of(m_prev);
    checks++; if (o_type !== 3'd5) begin errors++; $display("FAIL spawn_type got %0d exp 5", o_type); end
    checks++; if (o_next_type !== exp_next) begin errors++; $display("FAIL spawn_next got %0d exp %0d", o_next_type, exp_next); end
    checks++; if (o_x !== 5'd3 || o_y !== 5'd0) begin errors++; $display("FAIL spawn_xy got %0d,%0d exp 3,0", o_x, o_y); end
    cur_type = 3'd5;
    step;
    repeat (3) step;
    checks++; if (o_y !== 5'd0) begin errors++; $display("FAIL fall_pre1 got %0d exp 0", o_y); end
    step;
    checks++; if (o_y !== 5'd1) begin errors++; $display("FAIL fall_y1 got %0d exp 1", o_y); end
    repeat (3) step;
    checks++; if (o_y !== 5'd1) begin errors++; $display("FAIL fall_pre2 got %0d exp 1", o_y); end
    step;
    checks++; if (o_y !== 5'd2) begin errors++; $display("FAIL fall_y2 got %0d exp 2", o_y); end
  endtask

  task automatic test_rot_move;
    i_key_rot = 1; i_key_l = 1; i_eu = 1; i_el = 1; step; clear_keys;
    checks++; if (o_dir !== 2'd1 || o_x !== 5'd3) begin
      errors++; $display("FAIL rot_over_l got dir=%0d x=%0d exp 1/3", o_dir, o_x); end
    i_key_l = 1; step; clear_keys;
    checks++; if (o_x !== 5'd3) begin errors++; $display("FAIL left_blocked got %0d exp 3", o_x); end
    i_key_l = 1; i_el = 1; step; clear_keys;
    checks++; if (o_x !== 5'd2) begin errors++; $display("FAIL left_ok got %0d exp 2", o_x); end
    step;
    checks++; if (o_y !== 5'd3 || o_x !== 5'd2 || o_dir !== 2'd1) begin
      errors++; $display("FAIL move_tick got y=%0d x=%0d dir=%0d exp 3/2/1", o_y, o_x, o_dir); end
  endtask

  task automatic test_boom;
    i_cnt_boom = 0; i_key_boom = 1; step; clear_keys;
    checks++; if (o_boom !== 1'b0) begin errors++; $display("FAIL boom_empty got %b exp 0", o_boom); end
    step;
    checks++; if (o_boom !== 1'b0) begin errors++; $display("FAIL boom_empty2 got %b exp 0", o_boom); end
    i_cnt_boom = 2; i_key_boom = 1; step; clear_keys;
    checks++; if (o_boom !== 1'b1 || o_refresh !== 1'b0) begin
      errors++; $display("FAIL boom_fire got boom=%b refresh=%b exp 1/0", o_boom, o_refresh); end
    step;
    checks++; if (o_boom !== 1'b0 || o_y !== 5'd4) begin
      errors++; $display("FAIL boom_single got boom=%b y=%0d exp 0/4", o_boom, o_y); end
    repeat (3) step;
    i_key_boom = 1; step; clear_keys;
    checks++; if (o_boom !== 1'b0 || o_y !== 5'd5) begin
      errors++; $display("FAIL boom_vs_tick got boom=%b y=%0d exp 0/5", o_boom, o_y); end
    step;
    checks++; if (o_boom !== 1'b0) begin errors++; $display("FAIL boom_vs_tick2 got %b exp 0", o_boom); end
  endtask

  task automatic test_pause;
    step;
    i_pause = 1;
    for (int i = 0; i < 10; i++) begin
      i_key_r = (i % 2 == 0); i_er = 1; i_key_down = (i == 5);
      step;
      checks++; if (o_x !== 5'd2 || o_y !== 5'd5) begin
        errors++; $display("FAIL pause_hold%0d got x=%0d y=%0d exp 2/5", i, o_x, o_y); end
    end
    clear_keys; i_pause = 0;
    step;
    checks++; if (o_y !== 5'd5) begin errors++; $display("FAIL pause_resume got %0d exp 5", o_y); end
    step;
    checks++; if (o_y !== 5'd6) begin errors++; $display("FAIL pause_tick got %0d exp 6", o_y); end
    i_key_r = 1; i_er = 1; step; clear_keys;
    checks++; if (o_x !== 5'd3) begin errors++; $display("FAIL right_ok got %0d exp 3", o_x); end
  endtask

  task automatic test_lock;
    logic [2:0] prev_next;
    i_edrop = 0;
    step; step; step;
    checks++; if (o_refresh !== 1'b1 || o_y !== 5'd6 || o_x !== 5'd3 || o_type !== cur_type) begin
      errors++; $display("FAIL lock_enter got ref=%b y=%0d x=%0d type=%0d exp 1/6/3/%0d", o_refresh, o_y, o_x, o_type, cur_type); end
    step;
    checks++; if (o_refresh !== 1'b0 || o_playing !== 1'b1) begin
      errors++; $display("FAIL lock_pulse got ref=%b playing=%b exp 0/1", o_refresh, o_playing); end
    for (int i = 0; i < 9; i++) begin
      i_key_l = 1; i_el = 1; i_key_down = 1; i_edrop = 1;
      step;
    end
    clear_keys; i_edrop = 0;
    checks++; if (o_x !== 5'd3 || o_y !== 5'd6 || o_refresh !== 1'b0) begin
      errors++; $display("FAIL waitref_hold got x=%0d y=%0d ref=%b exp 3/6/0", o_x, o_y, o_refresh); end
    i_refresh_done = 1; step; i_refresh_done = 0;
    i_edrop = 1;
    step;
    prev_next = exp_next;
    exp_next = shape_of(m_prev);
    checks++; if (o_type !== prev_next || o_y !== 5'd0 || o_x !== 5'd3 || o_dir !== 2'd0) begin
      errors++; $display("FAIL respawn got type=%0d y=%0d x=%0d dir=%0d exp %0d/0/3/0", o_type, o_y, o_x, o_dir, prev_next); end
    checks++; if (o_next_type !== exp_next) begin errors++; $display("FAIL respawn_next got %0d exp %0d", o_next_type, exp_next); end
    cur_type = prev_next;
    step;
  endtask

  task automatic test_key_down;
    step;
    i_key_down = 1; step; clear_keys;
    checks++; if (o_y !== 5'd1) begin errors++; $display("FAIL down_move got %0d exp 1", o_y); end
    repeat (3) step;
    checks++; if (o_y !== 5'd1) begin errors++; $display("FAIL down_timer_rst got %0d exp 1", o_y); end
    step;
    checks++; if (o_y !== 5'd2) begin errors++; $display("FAIL down_tick got %0d exp 2", o_y); end
    i_edrop = 0; i_key_down = 1; step; clear_keys;
    checks++; if (o_refresh !== 1'b1 || o_y !== 5'd2) begin
      errors++; $display("FAIL down_lock got ref=%b y=%0d exp 1/2", o_refresh, o_y); end
    step;
  endtask

  task automatic test_over;
    i_refresh_done = 1; step; i_refresh_done = 0;
    i_overflow = 1;
    step; step;
    checks++; if (o_game_over !== 1'b1 || o_playing !== 1'b0) begin
      errors++; $display("FAIL over_enter got over=%b playing=%b exp 1/0", o_game_over, o_playing); end
    i_start = 1; step; i_start = 0;
    repeat (3) step;
    checks++; if (o_game_over !== 1'b1 || o_playing !== 1'b0) begin
      errors++; $display("FAIL over_absorb got over=%b playing=%b exp 1/0", o_game_over, o_playing); end
    rstn = 0; #1;
    checks++; if (o_game_over !== 1'b0 || o_type !== 3'd0 || o_x !== 5'd3 || o_next_type !== 3'd5) begin
      errors++; $display("FAIL over_reset got over=%b type=%0d x=%0d next=%0d exp 0/0/3/5", o_game_over, o_type, o_x, o_next_type); end
    step; rstn = 1; i_overflow = 0;
  endtask

  task automatic test_reset_midwait;
    i_start = 1; step; i_start = 0;
    step;
    checks++; if (o_type !== 3'd5) begin errors++; $display("FAIL reseed_type got %0d exp 5", o_type); end
    step;
    i_edrop = 0; i_key_down = 1; step; clear_keys;
    checks++; if (o_refresh !== 1'b1) begin errors++; $display("FAIL mid_lock got %b exp 1", o_refresh); end
    step;
    rstn = 0; #1;
    checks++; if (o_type !== 3'd0 || o_playing !== 1'b0 || o_refresh !== 1'b0 || o_y !== 5'd0 || o_dir !== 2'd0) begin
      errors++; $display("FAIL mid_reset got type=%0d playing=%b ref=%b y=%0d dir=%0d exp 0/0/0/0/0", o_type, o_playing, o_refresh, o_y, o_dir); end
    step; rstn = 1;
  endtask

  initial begin
    rstn = 0; i_start = 0; i_pause = 0; i_edrop = 0; i_overflow = 0;
    i_refresh_done = 0; i_cnt_boom = 0;
    clear_keys;
    cur_type = 0; exp_next = 0;
    repeat (2) step;
    test_reset;
    test_fall;
    test_rot_move;
    test_boom;
    test_pause;
    test_lock;
    test_key_down;
    test_over;
    test_reset_midwait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
